clmul_arbiter: RTL and testbench

CLMUL_ARBITER -- requirements
Module: clmul_arbiter

---
 rtl/clmul_arbiter.sv | 163 ++++++++++++++++
 tb/tb_clmul_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clmul_arbiter.sv
// Two-requester round-robin arbiter sharing one Karatsuba carry-less multiplier.
// Optional GF(2^K) reduction modulo POLY when CLMUL_REDUCE_EN is defined.
module clmul_arbiter #(
  parameter int unsigned K    = 8,
  parameter int unsigned LAT  = 2,
  parameter logic [K:0]  POLY = 9'h11B
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [K-1:0]   req0_a,
  input  logic [K-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [K-1:0]   req1_a,
  input  logic [K-1:0]   req1_b,
  output logic           req1_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*K-1:0] rsp_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic           rr_q, rr_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [K-1:0]   a_q, a_d, b_q, b_d;
  logic           id_q, id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic [2*K-1:0] rsp_data_q, rsp_data_d;
  logic           gnt, accept;
  logic [2*K-1:0] prod, result;

  if (K == 0 || LAT < 1 || LAT > 4 || POLY[K] != 1'b1) begin : g_bad_param
    $error("clmul_arbiter: illegal parameter combination");
  end

  function automatic logic [2*K-1:0] clmul_k(input logic [K-1:0] x, input logic [K-1:0] y);
    logic [2*K-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (x[i]) acc = acc ^ ({{K{1'b0}}, y} << i);
    end
    return acc;
  endfunction

  // One Karatsuba level: three half-size products instead of four.
  if (K == 1) begin : g_bit
    assign prod = {1'b0, a_q[0] & b_q[0]};
  end else begin : g_kara
    localparam int unsigned L = K / 2;
    logic [K-1:0]   a0, a1, b0, b1;
    logic [2*K-1:0] p0, p1, p2;
    assign a0 = K'(a_q[L-1:0]);
    assign a1 = K'(a_q[K-1:L]);
    assign b0 = K'(b_q[L-1:0]);
    assign b1 = K'(b_q[K-1:L]);
    assign p0 = clmul_k(a0, b0);
    assign p2 = clmul_k(a1, b1);
    assign p1 = clmul_k(a0 ^ a1, b0 ^ b1);
    assign prod = (p2 << (2 * L)) ^ ((p1 ^ p0 ^ p2) << L) ^ p0;
  end

`ifdef CLMUL_REDUCE_EN
  function automatic logic [K-1:0] gf_reduce(input logic [2*K-1:0] p);
    logic [2*K-1:0] r;
    int unsigned    j;
    r = p;
    for (int unsigned n = 0; n < K; n++) begin
      j = 2 * K - 1 - n;
      if (r[j]) r = r ^ ((2 * K)'(POLY) << (j - K));
    end
    return r[K-1:0];
  endfunction

  assign result = {{K{1'b0}}, gf_reduce(prod)};
`else
  assign result = prod;
`endif

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    gnt         = 1'b0;
    accept      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        // Tie goes to the requester not granted last; a lone requester always wins.
        if (req0_valid && req1_valid) gnt = ~rr_q;
        else                          gnt = req1_valid;
        accept     = req0_valid | req1_valid;
        req0_ready = accept & ~gnt;
        req1_ready = accept & gnt;
        if (accept) begin
          a_d     = gnt ? req1_a : req0_a;
          b_d     = gnt ? req1_b : req0_b;
          id_d    = gnt;
          rr_d    = gnt;
          cnt_d   = 3'(LAT - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = result;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b1;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_clmul_arbiter.sv
// Directed self-checking bench for clmul_arbiter: K=8/LAT=2 instance plus a K=1/LAT=1 instance.
module tb_clmul_arbiter;

`ifdef CLMUL_REDUCE_EN
  localparam logic [15:0] EXP_5783 = 16'h00C1;
  localparam logic [15:0] EXP_FFFF = 16'h0013;
  localparam logic [15:0] EXP_8080 = 16'h009A;
`else
  localparam logic [15:0] EXP_5783 = 16'h2B79;
  localparam logic [15:0] EXP_FFFF = 16'h5555;
  localparam logic [15:0] EXP_8080 = 16'h4000;
`endif

  logic        clk, rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_data;

  logic        k1_req0_valid, k1_req1_valid, k1_req0_ready, k1_req1_ready;
  logic [0:0]  k1_req0_a, k1_req0_b, k1_req1_a, k1_req1_b;
  logic        k1_rsp_valid, k1_rsp_ready, k1_rsp_id;
  logic [1:0]  k1_rsp_data;

  int errors = 0;
  int checks = 0;

  clmul_arbiter #(.K(8), .LAT(2), .POLY(9'h11B)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  clmul_arbiter #(.K(1), .LAT(1), .POLY(2'b11)) dut_k1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(k1_req0_valid), .req0_a(k1_req0_a), .req0_b(k1_req0_b), .req0_ready(k1_req0_ready),
    .req1_valid(k1_req1_valid), .req1_a(k1_req1_a), .req1_b(k1_req1_b), .req1_ready(k1_req1_ready),
    .rsp_valid(k1_rsp_valid), .rsp_ready(k1_rsp_ready), .rsp_id(k1_rsp_id), .rsp_data(k1_rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Single-requester transaction; returns observed response, no checking here.
  task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] data, output logic rid, output logic timeout);
    timeout = 1'b0;
    data    = '0;
    rid     = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) break;
      @(posedge clk); #1;
    end
    if (!rsp_valid) timeout = 1'b1;
    else begin data = rsp_data; rid = rsp_id; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {req1_ready, req0_ready}); end
    checks++; if ({k1_rsp_valid, k1_rsp_data} !== 3'b000) begin errors++; $display("FAIL reset_k1 got=%b exp=000", {k1_rsp_valid, k1_rsp_data}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_hold;
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h57; req0_b = 8'h83;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL basic_grant got=%b exp=01", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    // noise on request ports while the operation is in flight
    req0_a = 8'hFF; req0_b = 8'h00; req1_valid = 1'b1; req1_a = 8'h12; req1_b = 8'h34;
    #1;
    checks++; if ({rsp_valid, req1_ready, req0_ready} !== 3'b000) begin errors++; $display("FAIL busy_outputs got=%b exp=000", {rsp_valid, req1_ready, req0_ready}); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL latency_early got=%b exp=0", rsp_valid); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== EXP_5783) begin errors++; $display("FAIL basic_data got=%h exp=%h", rsp_data, EXP_5783); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL basic_id got=%b exp=0", rsp_id); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== EXP_5783 || rsp_id !== 1'b0 || {req1_ready, req0_ready} !== 2'b00) begin
        errors++;
        $display("FAIL hold_cycle%0d got v=%b d=%h id=%b rdy=%b exp v=1 d=%h id=0 rdy=00",
                 c, rsp_valid, rsp_data, rsp_id, {req1_ready, req0_ready}, EXP_5783);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL consume_valid got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_round_robin;
    logic got;
    logic exp_id;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    req0_a = 8'h03; req0_b = 8'h03; req1_a = 8'h05; req1_b = 8'h06;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2) == 1;
      got = 1'b0;
      for (int t = 0; t < 10; t++) begin
        if (req0_ready || req1_ready) begin got = 1'b1; break; end
        @(posedge clk); #1;
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL rr_grant_timeout txn=%0d got=none exp=grant", i); end
      checks++; if (req0_ready && req1_ready) begin errors++; $display("FAIL rr_exclusive txn=%0d got=11 exp=onehot", i); end
      checks++;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_grant txn=%0d got=%b exp=%b", i, {req1_ready, req0_ready}, exp_id ? 2'b10 : 2'b01);
      end
      @(posedge clk); #1;
      got = 1'b0;
      for (int t = 0; t < 10; t++) begin
        if (rsp_valid) begin got = 1'b1; break; end
        @(posedge clk); #1;
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL rr_rsp_timeout txn=%0d got=none exp=rsp", i); end
      checks++; if (rsp_id !== exp_id) begin errors++; $display("FAIL rr_rsp_id txn=%0d got=%b exp=%b", i, rsp_id, exp_id); end
      checks++;
      if (rsp_data !== (exp_id ? 16'h001E : 16'h0005)) begin
        errors++;
        $display("FAIL rr_rsp_data txn=%0d got=%h exp=%h", i, rsp_data, exp_id ? 16'h001E : 16'h0005);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_corners;
    logic        v_id  [5];
    logic [7:0]  v_a   [5];
    logic [7:0]  v_b   [5];
    logic [15:0] v_exp [5];
    logic [15:0] d;
    logic        r, to;
    v_id[0] = 1'b1; v_a[0] = 8'hFF; v_b[0] = 8'hFF; v_exp[0] = EXP_FFFF;
    v_id[1] = 1'b0; v_a[1] = 8'h00; v_b[1] = 8'hA5; v_exp[1] = 16'h0000;
    v_id[2] = 1'b0; v_a[2] = 8'hA5; v_b[2] = 8'h00; v_exp[2] = 16'h0000;
    v_id[3] = 1'b1; v_a[3] = 8'h01; v_b[3] = 8'hFF; v_exp[3] = 16'h00FF;
    v_id[4] = 1'b0; v_a[4] = 8'h80; v_b[4] = 8'h80; v_exp[4] = EXP_8080;
    for (int i = 0; i < 5; i++) begin
      run_op(v_id[i], v_a[i], v_b[i], d, r, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL corner_timeout vec=%0d got=timeout exp=rsp", i); end
      checks++; if (d !== v_exp[i]) begin errors++; $display("FAIL corner_data vec=%0d got=%h exp=%h", i, d, v_exp[i]); end
      checks++; if (r !== v_id[i]) begin errors++; $display("FAIL corner_id vec=%0d got=%b exp=%b", i, r, v_id[i]); end
    end
  endtask

  task automatic test_reset_busy;
    req0_valid = 1'b1; req0_a = 8'h57; req0_b = 8'h83;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rb_busy got=%b exp=0", rsp_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data, req1_ready, req0_ready} !== 20'h0) begin
      errors++;
      $display("FAIL rb_async_clear got v=%b id=%b d=%h rdy=%b exp all zero", rsp_valid, rsp_id, rsp_data, {req1_ready, req0_ready});
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rb_no_rsp cycle=%0d got=%b exp=0", c, rsp_valid); end
    end
    req0_a = 8'h03; req0_b = 8'h03; req1_a = 8'h05; req1_b = 8'h06;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL rb_tie_grant got=%b exp=01", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 16'h0005}) begin
      errors++;
      $display("FAIL rb_after_rsp got v=%b id=%b d=%h exp v=1 id=0 d=0005", rsp_valid, rsp_id, rsp_data);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_k1;
    k1_req0_valid = 1'b1; k1_req0_a = 1'b1; k1_req0_b = 1'b1;
    #1;
    checks++; if ({k1_req1_ready, k1_req0_ready} !== 2'b01) begin errors++; $display("FAIL k1_grant got=%b exp=01", {k1_req1_ready, k1_req0_ready}); end
    @(posedge clk); #1;
    k1_req0_valid = 1'b0;
    checks++; if (k1_rsp_valid !== 1'b0) begin errors++; $display("FAIL k1_early got=%b exp=0", k1_rsp_valid); end
    @(posedge clk); #1;
    checks++;
    if ({k1_rsp_valid, k1_rsp_id, k1_rsp_data} !== 4'b1001) begin
      errors++;
      $display("FAIL k1_11 got v=%b id=%b d=%b exp v=1 id=0 d=01", k1_rsp_valid, k1_rsp_id, k1_rsp_data);
    end
    k1_rsp_ready = 1'b1;
    @(posedge clk); #1;
    k1_rsp_ready = 1'b0;
    k1_req1_valid = 1'b1; k1_req1_a = 1'b1; k1_req1_b = 1'b0;
    @(posedge clk); #1;
    k1_req1_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({k1_rsp_valid, k1_rsp_id, k1_rsp_data} !== 4'b1100) begin
      errors++;
      $display("FAIL k1_10 got v=%b id=%b d=%b exp v=1 id=1 d=00", k1_rsp_valid, k1_rsp_id, k1_rsp_data);
    end
    k1_rsp_ready = 1'b1;
    @(posedge clk); #1;
    k1_rsp_ready = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    k1_req0_valid = 1'b0; k1_req1_valid = 1'b0; k1_rsp_ready = 1'b0;
    k1_req0_a = '0; k1_req0_b = '0; k1_req1_a = '0; k1_req1_b = '0;
    test_reset;
    test_basic_hold;
    test_round_robin;
    test_corners;
    test_reset_busy;
    test_k1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
